// File: rtl/round_robin_pop_pkg.sv
// Shared constants and helpers for the round-robin FIFO pop arbiter.
// The data width, FIFO count and index width are fixed for this design.
package round_robin_pop_pkg;

  localparam int DATA_W   = 6;
  localparam int NUM_FIFO = 4;
  localparam int IDX_W    = $clog2(NUM_FIFO);

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic [NUM_FIFO-1:0] onehot(input idx_t idx);
    logic [NUM_FIFO-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_next_idx.sv
// Combinational round-robin scan: finds the first non-empty FIFO after
// last_served, wrapping around, and reports whether any FIFO is ready.
module rr_next_idx
  import round_robin_pop_pkg::*;
(
  input  logic [NUM_FIFO-1:0] fifo_empty,
  input  idx_t                last_served,
  output idx_t                next_idx,
  output logic                any_ready
);

  idx_t cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    next_idx  = last_served;
    any_ready = 1'b0;
    cand      = '0;
    // NUM_FIFO is a power of two, so index wrap-around is plain truncation.
    for (int k = 1; k <= NUM_FIFO; k++) begin
      cand = last_served + IDX_W'(k);
      if (!any_ready && !fifo_empty[cand]) begin
        next_idx  = cand;
        any_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_pop.sv
// Pops N upstream FIFOs in round-robin order and forwards each word to a
// downstream FIFO two cycles later, with pause flow control and error checks.
module round_robin_pop
  import round_robin_pop_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int N  = NUM_FIFO
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    fifo_empty,
  input  logic [N*DW-1:0] data_in,
  input  logic [N-1:0]    valid_in,
  input  logic            almost_full_down,
  input  logic            almost_empty_down,
  output logic [N-1:0]    pop,
  output logic            push,
  output logic [DW-1:0]   data_out,
  output logic            paused,
  output logic            error_out
);

  idx_t         last_served;
  idx_t         next_idx;
  idx_t         flight_idx;
  logic         any_ready;
  logic         flight_valid;
  logic         pop_fire;
  logic         take;
  logic [N-1:0] expected;

  rr_next_idx u_next_idx (
    .fifo_empty (fifo_empty),
    .last_served(last_served),
    .next_idx   (next_idx),
    .any_ready  (any_ready)
  );

  // Pop is issued combinationally so the upstream FIFO sees it on this edge.
  assign pop_fire = any_ready && !paused && !reset;
  assign pop      = pop_fire ? onehot(next_idx) : '0;

  // The only valid_in pattern allowed this cycle follows from last cycle's pop.
  assign expected = flight_valid ? onehot(flight_idx) : '0;
  assign take     = flight_valid && valid_in[flight_idx];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      last_served  <= IDX_W'(N - 1);
      flight_valid <= 1'b0;
      flight_idx   <= '0;
      push         <= 1'b0;
      data_out     <= '0;
      paused       <= 1'b0;
      error_out    <= 1'b0;
    end else begin
      if (pop_fire) begin
        last_served <= next_idx;
      end
      flight_valid <= pop_fire;
      flight_idx   <= next_idx;
      push         <= take;
      if (take) begin
        data_out <= data_in[flight_idx*DW +: DW];
      end
      error_out <= (valid_in != expected);
      // Pause request has priority over release.
      if (almost_full_down) begin
        paused <= 1'b1;
      end else if (almost_empty_down) begin
        paused <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_round_robin_pop.sv
// Directed self-checking bench for round_robin_pop: arbitration order,
// pop->push latency, pause flow control, protocol errors and reset.
module tb_round_robin_pop;
  import round_robin_pop_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_FIFO-1:0]      fifo_empty;
  logic [NUM_FIFO*DATA_W-1:0] data_in;
  logic [NUM_FIFO-1:0]      valid_in;
  logic                     almost_full_down;
  logic                     almost_empty_down;
  logic [NUM_FIFO-1:0]      pop;
  logic                     push;
  logic [DATA_W-1:0]        data_out;
  logic                     paused;
  logic                     error_out;

  int checks = 0;
  int errors = 0;

  logic                auto_resp;
  logic [NUM_FIFO-1:0] pop_q;
  logic [DATA_W-1:0]   word [NUM_FIFO] = '{6'h05, 6'h1A, 6'h2C, 6'h33};

  always #5 clk = ~clk;

  round_robin_pop dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .data_in          (data_in),
    .valid_in         (valid_in),
    .almost_full_down (almost_full_down),
    .almost_empty_down(almost_empty_down),
    .pop              (pop),
    .push             (push),
    .data_out         (data_out),
    .paused           (paused),
    .error_out        (error_out)
  );

  function automatic int idx_of(input logic [NUM_FIFO-1:0] oh);
    int r = 0;
    for (int i = 0; i < NUM_FIFO; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Samples pop just before the edge, then models the upstream FIFOs
  // returning valid_in one cycle after each pop. Returns 2 time units after the edge.
  task automatic run_cycle();
    #1;
    pop_q = pop;
    @(posedge clk);
    #2;
    valid_in = auto_resp ? pop_q : '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_empty = '0; valid_in = '0;
    almost_full_down = 1'b0; almost_empty_down = 1'b0; auto_resp = 1'b1;
    data_in = {word[3], word[2], word[1], word[0]};
    run_cycle();
    run_cycle();
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop: got %b expected 0000", pop); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b expected 0", push); end
    checks++; if (data_out !== 6'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %b expected 0", paused); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error_out); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset = 1'b0; fifo_empty = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (pop !== exp_pop[c]) begin errors++; $display("FAIL rr_pop[%0d]: got %b expected %b", c, pop, exp_pop[c]); end
      run_cycle();
      if (c >= 1) begin
        checks++;
        if (push !== 1'b1 || data_out !== word[idx_of(exp_pop[c-1])]) begin
          errors++; $display("FAIL rr_push[%0d]: got push=%b data=%h expected push=1 data=%h", c, push, data_out, word[idx_of(exp_pop[c-1])]);
        end
      end else begin
        checks++; if (push !== 1'b0) begin errors++; $display("FAIL rr_push_first: got %b expected 0", push); end
      end
    end
    fifo_empty = '1;
    run_cycle();
    checks++; if (push !== 1'b1 || data_out !== word[3]) begin errors++; $display("FAIL rr_last_push: got push=%b data=%h expected push=1 data=%h", push, data_out, word[3]); end
    run_cycle();
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL rr_drain: got push=%b expected 0", push); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL rr_error: got %b expected 0", error_out); end
  endtask

  task automatic test_skip_empty();
    logic [3:0] exp_pop [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    fifo_empty = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (pop !== exp_pop[c]) begin errors++; $display("FAIL skip_pop[%0d]: got %b expected %b", c, pop, exp_pop[c]); end
      run_cycle();
      if (c >= 1) begin
        checks++;
        if (push !== 1'b1 || data_out !== word[idx_of(exp_pop[c-1])]) begin
          errors++; $display("FAIL skip_push[%0d]: got push=%b data=%h expected push=1 data=%h", c, push, data_out, word[idx_of(exp_pop[c-1])]);
        end
      end
    end
    fifo_empty = '1;
    run_cycle();
    checks++; if (push !== 1'b1 || data_out !== word[2]) begin errors++; $display("FAIL skip_last_push: got push=%b data=%h expected push=1 data=%h", push, data_out, word[2]); end
    run_cycle();
  endtask

  task automatic test_pause();
    fifo_empty = '0;
    #1;
    checks++; if (pop !== 4'b1000) begin errors++; $display("FAIL pause_pop_a0: got %b expected 1000", pop); end
    run_cycle();
    almost_full_down = 1'b1;
    #1;
    checks++; if (pop !== 4'b0001) begin errors++; $display("FAIL pause_pop_a: got %b expected 0001", pop); end
    run_cycle();
    almost_full_down = 1'b0;
    #1;
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_set: got %b expected 1", paused); end
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL pause_hold_pop: got %b expected 0000", pop); end
    checks++; if (push !== 1'b1 || data_out !== word[3]) begin errors++; $display("FAIL pause_inflight1: got push=%b data=%h expected push=1 data=%h", push, data_out, word[3]); end
    run_cycle();
    checks++; if (push !== 1'b1 || data_out !== word[0]) begin errors++; $display("FAIL pause_inflight2: got push=%b data=%h expected push=1 data=%h", push, data_out, word[0]); end
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL pause_hold_pop2: got %b expected 0000", pop); end
    run_cycle();
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL pause_no_third: got push=%b expected 0", push); end
    almost_empty_down = 1'b1;
    run_cycle();
    almost_empty_down = 1'b0;
    #1;
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_clear: got %b expected 0", paused); end
    checks++; if (pop !== 4'b0010) begin errors++; $display("FAIL pause_resume_pop: got %b expected 0010", pop); end
    run_cycle();
    fifo_empty = '1;
    run_cycle();
    checks++; if (push !== 1'b1 || data_out !== word[1]) begin errors++; $display("FAIL pause_resume_push: got push=%b data=%h expected push=1 data=%h", push, data_out, word[1]); end
    almost_full_down = 1'b1; almost_empty_down = 1'b1;
    run_cycle();
    almost_full_down = 1'b0; almost_empty_down = 1'b0;
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_both: got %b expected 1", paused); end
    almost_empty_down = 1'b1;
    run_cycle();
    almost_empty_down = 1'b0;
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_both_release: got %b expected 0", paused); end
    run_cycle();
  endtask

  task automatic test_error();
    auto_resp = 1'b0; fifo_empty = '1;
    valid_in = 4'b0100;
    run_cycle();
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL err_unexpected: got %b expected 1", error_out); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL err_unexpected_push: got %b expected 0", push); end
    run_cycle();
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", error_out); end
    fifo_empty = 4'b1110;
    #1;
    checks++; if (pop !== 4'b0001) begin errors++; $display("FAIL err_pop: got %b expected 0001", pop); end
    run_cycle();
    fifo_empty = '1;
    run_cycle();
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL err_missing: got %b expected 1", error_out); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL err_missing_push: got %b expected 0", push); end
    run_cycle();
    checks++; if (error_out !== 1'b0 || push !== 1'b0) begin errors++; $display("FAIL err_quiet: got error=%b push=%b expected 0 0", error_out, push); end
    auto_resp = 1'b1;
  endtask

  task automatic test_reset_mid();
    fifo_empty = 4'b1101;
    #1;
    checks++; if (pop !== 4'b0010) begin errors++; $display("FAIL rst_mid_pop: got %b expected 0010", pop); end
    run_cycle();
    reset = 1'b1; fifo_empty = '0;
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL rst_mid_gate: got %b expected 0000", pop); end
    run_cycle();
    reset = 1'b0;
    #1;
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL rst_mid_push0: got %b expected 0", push); end
    checks++; if (pop !== 4'b0001) begin errors++; $display("FAIL rst_mid_first_pop: got %b expected 0001", pop); end
    run_cycle();
    fifo_empty = '1;
    checks++; if (push !== 1'b0 || error_out !== 1'b0) begin errors++; $display("FAIL rst_mid_discard: got push=%b error=%b expected 0 0", push, error_out); end
    run_cycle();
    checks++; if (push !== 1'b1 || data_out !== word[0]) begin errors++; $display("FAIL rst_mid_push: got push=%b data=%h expected push=1 data=%h", push, data_out, word[0]); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_empty();
    test_pause();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
